// File: rtl/layer_sequencer.sv
// Sequences NUM_STAGES compute layers through a one-hot start/done handshake, with a
// runtime skip mask, per-stage watchdog, abort, restart and a saturating run-cycle counter.
module layer_sequencer #(
    parameter int NUM_STAGES     = 18,
    parameter int IDX_W          = $clog2(NUM_STAGES),
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_en,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      cur_stage,
    output logic [IDX_W-1:0]      err_stage,
    output logic [CNT_W-1:0]      total_cycles
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [NUM_STAGES-1:0] ONE_HOT0 = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [NUM_STAGES-1:0] start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [IDX_W-1:0]      err_q, err_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic                  first_found, next_found;
    logic [IDX_W-1:0]      first_idx, next_idx;
    logic                  accept, honoured, timed_out;

    // Lowest enabled stage of a new run, and lowest latched stage above the current one.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_en[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_q))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    // A zero watchdog marks the first RUN cycle, where a stale done level must be ignored.
    assign accept    = start && !abort &&
                       ((state_q == S_IDLE) || (state_q == S_FINISH) || (state_q == S_ERROR));
    assign honoured  = stage_done[cur_q] && (wd_q != '0);
    assign timed_out = (TIMEOUT_CYCLES > 0) && ((int'(wd_q) + 1) >= TIMEOUT_CYCLES);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        start_d = start_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        cur_d   = cur_q;
        err_d   = err_q;
        total_d = total_q;
        wd_d    = wd_q;

        case (state_q)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (accept) begin
                    mask_d  = stage_en;
                    total_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    if (first_found) begin
                        state_d = S_RUN;
                        start_d = ONE_HOT0 << first_idx;
                        cur_d   = first_idx;
                        busy_d  = 1'b1;
                        wd_d    = '0;
                    end else begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (honoured) begin
                    state_d = S_GAP;
                    start_d = '0;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    start_d = '0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    err_d   = cur_q;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GAP: begin
                if (next_found) begin
                    state_d = S_RUN;
                    start_d = ONE_HOT0 << next_idx;
                    cur_d   = next_idx;
                    wd_d    = '0;
                end else begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                start_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            start_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end

        // The counter follows the registered busy flag; the accepting cycle only clears it.
        if (busy_d && !accept && (total_q != '1)) begin
            total_d = total_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cur_q   <= '0;
            err_q   <= '0;
            total_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
            total_q <= total_d;
            wd_q    <= wd_d;
        end
    end

    assign stage_start  = start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cur_stage    = cur_q;
    assign err_stage    = err_q;
    assign total_cycles = total_q;

endmodule
